// File: rtl/mtrx_pkg.sv
// Shared constants and FSM state encoding for the matrix operand loader.
package mtrx_pkg;

  localparam int unsigned MTRX_DIM   = 5;
  localparam int unsigned MTRX_WIDTH = 8;
  localparam int unsigned MTRX_ELEMS = MTRX_DIM * MTRX_DIM;
  localparam int unsigned MTRX_BITS  = MTRX_ELEMS * MTRX_WIDTH;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } mtrx_state_t;

endpackage

// File: rtl/mtrx_elem_counter.sv
// Element index counter: 0..ELEMS-1 with enable, synchronous clear and terminal-count flag.
module mtrx_elem_counter #(
  parameter int unsigned ELEMS = 25,
  parameter int unsigned CW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

  assign tc = (count == LAST);

  // Advancing from the last index returns to 0; the count never exceeds LAST.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mtrx_loader.sv
// Streams two DIMxDIM row-major matrices element by element into packed operand registers a and b.
module mtrx_loader
  import mtrx_pkg::*;
#(
  parameter int unsigned DIM   = MTRX_DIM,
  parameter int unsigned WIDTH = MTRX_WIDTH,
  localparam int unsigned ELEMS = DIM * DIM,
  localparam int unsigned CW    = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [ELEMS*WIDTH-1:0] a,
  output logic [ELEMS*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          elem_count
);

  mtrx_state_t state, state_n;
  logic        xfer;
  logic        last;
  logic        wr_a, wr_b;

  assign in_ready = (state != HOLD);
  assign xfer     = in_valid && in_ready;
  assign wr_a     = xfer && !abort && (state == LOAD_A);
  assign wr_b     = xfer && !abort && (state == LOAD_B);

  mtrx_elem_counter #(
    .ELEMS (ELEMS),
    .CW    (CW)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (abort),
    .enable (xfer && !abort),
    .count  (elem_count),
    .tc     (last)
  );

  always_comb begin
    state_n = state;
    case (state)
      LOAD_A:  if (xfer && last) state_n = LOAD_B;
      LOAD_B:  if (xfer && last) state_n = HOLD;
      HOLD:    if (out_ready)    state_n = LOAD_A;
      default: state_n = LOAD_A;
    endcase
    if (abort) state_n = LOAD_A;
  end

  // out_valid is registered from the next state so it is high exactly while in HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOAD_A;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == HOLD);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else begin
      for (int unsigned k = 0; k < ELEMS; k++) begin
        if (elem_count == CW'(k)) begin
          if (wr_a) a[k*WIDTH +: WIDTH] <= in_data;
          if (wr_b) b[k*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtrx_loader.sv
// Scoreboard bench for mtrx_loader: directed scenarios plus randomized traffic against a queue-based model.
module tb_mtrx_loader;

  localparam int DIM   = 5;
  localparam int WIDTH = 8;
  localparam int ELEMS = DIM * DIM;
  localparam int BITS  = ELEMS * WIDTH;
  localparam int PAIR  = 2 * ELEMS;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic [BITS-1:0]  a, b;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       elem_count;

  always #5 clock = ~clock;

  mtrx_loader #(
    .DIM   (DIM),
    .WIDTH (WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .elem_count (elem_count)
  );

  // Reference model: the elements accepted so far for the current pair, and the matrix contents.
  logic [WIDTH-1:0] ma [ELEMS];
  logic [WIDTH-1:0] mb [ELEMS];
  int unsigned      len;
  bit               started = 1'b0;

  typedef struct {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
  } pair_t;
  pair_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [BITS-1:0] pack(input logic [WIDTH-1:0] m [ELEMS]);
    logic [BITS-1:0] v;
    for (int k = 0; k < ELEMS; k++) v[k*WIDTH +: WIDTH] = m[k];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] stream_val(input int n);
    return (n < ELEMS) ? WIDTH'(n + 1) : WIDTH'(PAIR - n);
  endfunction

  task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // What the loader must do at the clock edge just taken, given the inputs the bench drove.
  task automatic model_step();
    if (reset) begin
      for (int k = 0; k < ELEMS; k++) begin
        ma[k] = '0;
        mb[k] = '0;
      end
      len     = 0;
      started = 1'b1;
      exp_q.delete();
    end else if (!started) begin
      len = 0;
    end else if (abort) begin
      len = 0;
    end else if (len == PAIR) begin
      if (out_ready) len = 0;
    end else if (in_valid) begin
      if (len < ELEMS) ma[len] = in_data;
      else             mb[len - ELEMS] = in_data;
      len++;
      if (len == PAIR) exp_q.push_back('{pack(ma), pack(mb)});
    end
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit ab, input bit rdy, input bit rst);
    in_valid  = v;
    in_data   = d;
    abort     = ab;
    out_ready = rdy;
    reset     = rst;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic stream(input bit toggle, input bit rdy, input bit rnd);
    for (int n = 0; n < PAIR; n++) begin
      if (toggle) drive(1'b0, 8'h00, 1'b0, rdy, 1'b0);
      drive(1'b1, rnd ? WIDTH'($urandom) : stream_val(n), 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic check_adder();
    logic [BITS-1:0] s, e;
    for (int k = 0; k < ELEMS; k++) begin
      s[k*WIDTH +: WIDTH] = a[k*WIDTH +: WIDTH] + b[k*WIDTH +: WIDTH];
      e[k*WIDTH +: WIDTH] = 8'd26;
    end
    chk("adder_sum", s, e);
  endtask

  // Monitor: per-cycle state checks, and a scoreboard pop whenever a new operand pair is presented.
  initial begin
    bit    popped = 1'b0;
    pair_t p;
    int unsigned exp_cnt;
    forever begin
      @(negedge clock);
      if (started) begin
        exp_cnt = (len >= PAIR) ? 0 : len % ELEMS;
        chk("in_ready",   BITS'(in_ready),   BITS'(len < PAIR));
        chk("out_valid",  BITS'(out_valid),  BITS'(len == PAIR));
        chk("elem_count", BITS'(elem_count), BITS'(exp_cnt));
        chk("a_contents", a, pack(ma));
        chk("b_contents", b, pack(mb));
        if (out_valid && !popped) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_pop: out_valid=1 but no operand pair was expected");
          end else begin
            p = exp_q.pop_front();
            chk("pair_a", a, p.a);
            chk("pair_b", b, p.b);
          end
          popped = 1'b1;
        end
        if (!out_valid) popped = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 1..25 then 25..1 with in_valid held high; hold with junk input; then release.
    stream(1'b0, 1'b0, 1'b0);
    check_adder();
    repeat (5) drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Same stream with in_valid toggling.
    stream(1'b1, 1'b0, 1'b0);
    check_adder();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Abort together with a transfer at A element 10, then a full reload.
    for (int n = 0; n < 10; n++) drive(1'b1, 8'hC0 + 8'(n), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    stream(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset during LOAD_B at element 7.
    for (int n = 0; n < ELEMS + 7; n++) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // out_ready already high on the first HOLD cycle, then a second pair.
    stream(1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    stream(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional abort and reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, WIDTH'($urandom), $urandom_range(0, 199) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    chk("scoreboard_drained", BITS'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mtrx_loader.md
MTRX_LOADER -- requirements
Module: mtrx_loader

Interface
REQ-001 SHALL have parameter DIM, default 5, meaning matrix rows = columns.
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per element.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  WIDTH  one matrix element per transfer.
REQ-006 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port abort  input  1  discard the partial load and restart at A element 0.
REQ-009 SHALL have port a  output  DIM*DIM*WIDTH (200)  packed matrix A, element k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port b  output  DIM*DIM*WIDTH (200)  packed matrix B, same packing as a.
REQ-011 SHALL have port out_valid  output  1  a and b hold a complete operand pair.
REQ-012 SHALL have port out_ready  input  1  downstream adder has consumed the pair.
REQ-013 SHALL have port elem_count  output  5  index of the next element to be written (0..24).

Function
REQ-014 SHALL map element (row r, column c) to index k = r*DIM + c, row-major.
REQ-015 SHALL implement the states LOAD_A, LOAD_B and HOLD.
REQ-016 SHALL define a transfer as in_valid=1 and in_ready=1 in the same cycle.
REQ-017 SHALL drive in_ready=1 in LOAD_A and LOAD_B, and in_ready=0 in HOLD.
REQ-018 SHALL, on each transfer in LOAD_A, write in_data to a[elem_count] and increment elem_count.
REQ-019 SHALL, on each transfer in LOAD_B, write in_data to b[elem_count] and increment elem_count.
REQ-020 SHALL, on a transfer at elem_count=24 in LOAD_A, set elem_count to 0 and move to LOAD_B.
REQ-021 SHALL, on a transfer at elem_count=24 in LOAD_B, set elem_count to 0 and move to HOLD.
REQ-022 SHALL register out_valid: it reads 1 exactly when the state is HOLD, i.e. the cycle after the 50th transfer.
REQ-023 SHALL hold a and b stable for every cycle in which out_valid=1.
REQ-024 SHALL, in HOLD with out_ready=1, move to LOAD_A and deassert out_valid on the next cycle.
REQ-025 SHALL leave a and b unchanged on that HOLD-to-LOAD_A transition; they are overwritten element by element.
REQ-026 SHALL ignore in_valid while in HOLD, with no write and no count change.
REQ-027 SHALL, on abort=1 in any state, move to LOAD_A with elem_count=0 on the next cycle.
REQ-028 SHALL give abort priority over a simultaneous transfer or out_ready; no element is written in that cycle.
REQ-029 SHALL leave a and b unchanged on abort.
REQ-030 SHALL keep elem_count unchanged in any cycle without a transfer (in_valid=0 stalls).
REQ-031 SHALL never wrap elem_count past 24.

Reset
REQ-032 SHALL, while reset=1 at a clock edge, clear a and b to 0 and elem_count to 0, enter LOAD_A, and drive out_valid=0.
REQ-033 SHALL give reset priority over abort, transfers and out_ready, including mid-load and mid-HOLD.
REQ-034 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-035 SHALL place MTRX_DIM=5, MTRX_WIDTH=8, MTRX_ELEMS=25, MTRX_BITS=200 and the state enum in the shared package mtrx_pkg.
REQ-036 SHALL contain one sub-module, mtrx_elem_counter: a 0..24 counter with enable, synchronous clear and terminal-count flag.
REQ-037 SHALL allow a and b to connect directly to the adder's a and b inputs, with out_valid qualifying them.

Verification
REQ-038 SHALL cover: after reset, stream 1..25 then 25..1 with in_valid held high -> out_valid=1 on the cycle after the 50th byte; a element 0 = 8'd1, a element 24 = 8'd25, b element 0 = 8'd25; adder output = all 8'd26.
REQ-039 SHALL cover: the same stream with in_valid toggling every other cycle -> identical a and b; elem_count frozen in the gaps.
REQ-040 SHALL cover: in HOLD, drive in_valid=1 with data 8'hFF for 5 cycles, out_ready=0 -> a and b unchanged, in_ready=0, out_valid stays 1.
REQ-041 SHALL cover: abort at A element 10 together with a transfer -> that element is not written, elem_count=0, state LOAD_A; a full reload then completes normally.
REQ-042 SHALL cover: reset asserted during LOAD_B at element 7 -> a=0, b=0, elem_count=0, out_valid=0 on the next cycle.
REQ-043 SHALL cover: out_ready=1 in the first HOLD cycle -> out_valid=0 and in_ready=1 on the next cycle; a second operand pair loads correctly.
